speck_round_engine: RTL and testbench



---
 rtl/speck_pkg.sv | 35 +++
 rtl/speck_round_comb.sv | 35 +++
 rtl/speck_round_engine.sv | 96 +++++++++
 tb/tb_speck_round_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_pkg.sv
// Shared definitions for the SPECK round engine: FSM state codes, mode
// constants and width-generic rotation helpers.
package speck_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ROUND = 4'd1,
    DONE  = 4'd2
  } state_t;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  // Rotate the low w bits of v right by amt (0 <= amt <= w <= 64).
  // Bits above w are cleared on input and output, so callers can zero-extend
  // a narrower word, rotate, and truncate the result back.
  function automatic logic [63:0] ror(input logic [63:0] v,
                                      input int unsigned amt,
                                      input int unsigned w);
    logic [63:0] mask;
    logic [63:0] vm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    vm   = v & mask;
    return ((vm >> amt) | (vm << (w - amt))) & mask;
  endfunction

  // Rotate the low w bits of v left by amt, expressed as the complementary
  // right rotation.
  function automatic logic [63:0] rol(input logic [63:0] v,
                                      input int unsigned amt,
                                      input int unsigned w);
    return ror(v, w - amt, w);
  endfunction

endpackage

// File: rtl/speck_round_comb.sv
// One SPECK round, encrypt or decrypt, purely combinational.
module speck_round_comb
  import speck_pkg::*;
#(
  parameter int unsigned WORD  = 64,
  parameter int unsigned ALPHA = 8,
  parameter int unsigned BETA  = 3
) (
  input  logic [WORD-1:0] x,
  input  logic [WORD-1:0] y,
  input  logic [WORD-1:0] k,
  input  logic            mode,
  output logic [WORD-1:0] x_next,
  output logic [WORD-1:0] y_next
);

  logic [WORD-1:0] tx;
  logic [WORD-1:0] ty;

  // Round function; arithmetic wraps modulo 2^WORD by operand width.
  always_comb begin
    tx = '0;
    ty = '0;
    if (mode == ENC) begin
      tx = (WORD'(ror(64'(x), ALPHA, WORD)) + y) ^ k;
      ty = WORD'(rol(64'(y), BETA, WORD)) ^ tx;
    end else begin
      ty = WORD'(ror(64'(x ^ y), BETA, WORD));
      tx = WORD'(rol(64'((x ^ k) - ty), ALPHA, WORD));
    end
    x_next = tx;
    y_next = ty;
  end

endmodule

// File: rtl/speck_round_engine.sv
// Iterative SPECK core: one round per clock, round keys fetched by index
// from an external key-schedule store with a valid handshake.
module speck_round_engine
  import speck_pkg::*;
#(
  parameter  int unsigned WORD   = 64,
  parameter  int unsigned ROUNDS = 32,
  parameter  int unsigned ALPHA  = 8,
  parameter  int unsigned BETA   = 3,
  localparam int unsigned KW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signal_start,
  input  logic              mode,
  input  logic [2*WORD-1:0] plaintext,
  input  logic [WORD-1:0]   subkey,
  input  logic              subkey_valid,
  output logic [KW-1:0]     key_idx,
  output logic [2*WORD-1:0] ciphertext,
  output logic              busy,
  output logic              finished,
  output logic [3:0]        state_response
);

  localparam logic [KW-1:0] LAST_IDX = KW'(ROUNDS - 1);
  localparam logic [KW-1:0] ONE      = KW'(1);

  state_t          state;
  logic            mode_r;
  logic [KW-1:0]   rcnt;
  logic [WORD-1:0] x_r;
  logic [WORD-1:0] y_r;
  logic [WORD-1:0] x_n;
  logic [WORD-1:0] y_n;

  speck_round_comb #(
    .WORD  (WORD),
    .ALPHA (ALPHA),
    .BETA  (BETA)
  ) u_round (
    .x      (x_r),
    .y      (y_r),
    .k      (subkey),
    .mode   (mode_r),
    .x_next (x_n),
    .y_next (y_n)
  );

  assign ciphertext     = {x_r, y_r};
  assign busy           = (state == ROUND);
  assign state_response = state;

  // Job sequencer: latch block on start, step one round per valid key,
  // pulse finished while in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_r   <= ENC;
      rcnt     <= '0;
      key_idx  <= '0;
      x_r      <= '0;
      y_r      <= '0;
      finished <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (signal_start) begin
            x_r     <= plaintext[2*WORD-1:WORD];
            y_r     <= plaintext[WORD-1:0];
            mode_r  <= mode;
            rcnt    <= '0;
            key_idx <= (mode == DEC) ? LAST_IDX : '0;
            state   <= ROUND;
          end
        end
        ROUND: begin
          if (subkey_valid) begin
            x_r     <= x_n;
            y_r     <= y_n;
            rcnt    <= rcnt + ONE;
            key_idx <= (mode_r == DEC) ? (key_idx - ONE) : (key_idx + ONE);
            if (rcnt == LAST_IDX) begin
              state    <= DONE;
              finished <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speck_round_engine.sv
// Self-checking bench for speck_round_engine: SPECK128/128 full jobs,
// one-round vectors at WORD=64 and WORD=32, stalls, stray starts, reset.
module tb_speck_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 32-round SPECK128/128 instance
  logic         m_start, m_mode, m_valid;
  logic [127:0] m_pt, m_ct;
  logic [63:0]  m_subkey;
  logic [4:0]   m_kidx;
  logic         m_busy, m_fin;
  logic [3:0]   m_st;
  logic [63:0]  rk [32];
  assign m_subkey = rk[m_kidx];

  // one-round WORD=64 instance
  logic         a_start, a_mode, a_valid;
  logic [127:0] a_pt, a_ct;
  logic [63:0]  a_key;
  logic         a_kidx, a_busy, a_fin;
  logic [3:0]   a_st;

  // one-round WORD=32 instance
  logic         b_start, b_mode, b_valid;
  logic [63:0]  b_pt, b_ct;
  logic [31:0]  b_key;
  logic         b_kidx, b_busy, b_fin;
  logic [3:0]   b_st;

  speck_round_engine #(.WORD(64), .ROUNDS(32), .ALPHA(8), .BETA(3)) dut_main (
    .clk(clk), .rst(rst), .signal_start(m_start), .mode(m_mode), .plaintext(m_pt),
    .subkey(m_subkey), .subkey_valid(m_valid), .key_idx(m_kidx), .ciphertext(m_ct),
    .busy(m_busy), .finished(m_fin), .state_response(m_st));

  speck_round_engine #(.WORD(64), .ROUNDS(1), .ALPHA(8), .BETA(3)) dut_r1 (
    .clk(clk), .rst(rst), .signal_start(a_start), .mode(a_mode), .plaintext(a_pt),
    .subkey(a_key), .subkey_valid(a_valid), .key_idx(a_kidx), .ciphertext(a_ct),
    .busy(a_busy), .finished(a_fin), .state_response(a_st));

  speck_round_engine #(.WORD(32), .ROUNDS(1), .ALPHA(8), .BETA(3)) dut_w32 (
    .clk(clk), .rst(rst), .signal_start(b_start), .mode(b_mode), .plaintext(b_pt),
    .subkey(b_key), .subkey_valid(b_valid), .key_idx(b_kidx), .ciphertext(b_ct),
    .busy(b_busy), .finished(b_fin), .state_response(b_st));

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [127:0] m_q[$];
  logic [127:0] a_q[$];
  logic [127:0] b_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Scoreboards: every finished pulse pops and compares one expected block.
  always @(negedge clk) begin
    if (m_fin) begin
      if (m_q.size() == 0) check("main_unexpected_finished", 128'(m_fin), 128'd0);
      else check("main_result", m_ct, m_q.pop_front());
    end
    if (a_fin) begin
      if (a_q.size() == 0) check("r1_unexpected_finished", 128'(a_fin), 128'd0);
      else check("r1_result", a_ct, a_q.pop_front());
    end
    if (b_fin) begin
      if (b_q.size() == 0) check("w32_unexpected_finished", 128'(b_fin), 128'd0);
      else check("w32_result", 128'(b_ct), b_q.pop_front());
    end
  end

  // Reference SPECK128 pieces, written with plain bit concatenation.
  function automatic logic [63:0] r8(input logic [63:0] v);
    return {v[7:0], v[63:8]};
  endfunction
  function automatic logic [63:0] l3(input logic [63:0] v);
    return {v[60:0], v[63:61]};
  endfunction
  function automatic logic [127:0] enc_model(input logic [127:0] pt);
    logic [63:0] x, y;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 32; i++) begin
      x = (r8(x) + y) ^ rk[i];
      y = l3(y) ^ x;
    end
    return {x, y};
  endfunction

  task automatic run_main(input logic mode, input logic [127:0] pt, input logic [127:0] exp,
                          input int nstall, input bit pulse, input string name);
    int s[3];
    int edges;
    bit stall_now;
    logic [4:0] kid;
    s[0] = int'($urandom_range(2, 8));
    s[1] = s[0] + int'($urandom_range(1, 6));
    s[2] = s[1] + int'($urandom_range(1, 6));
    @(posedge clk); #1;
    m_start = 1'b1; m_mode = mode; m_pt = pt; m_valid = 1'b1;
    m_q.push_back(exp);
    @(posedge clk); #1;
    m_start = 1'b0; m_pt = ~pt;
    check({name, "_round_state"}, 128'({m_busy, m_st}), 128'(5'b1_0001));
    check({name, "_first_kidx"}, 128'(m_kidx), (mode ? 128'd31 : 128'd0));
    edges = 0;
    stall_now = 1'b0;
    kid = '0;
    while (1) begin
      @(negedge clk);
      if (m_fin || edges > 200) break;
      @(posedge clk); #1;
      edges++;
      if (stall_now) check({name, "_kidx_held"}, 128'(m_kidx), 128'(kid));
      stall_now = (nstall > 0) && (edges == s[0] || edges == s[1] || edges == s[2]);
      m_valid = ~stall_now;
      kid = m_kidx;
      if (pulse) begin
        m_start = (edges == 10 || edges == 11);
        m_mode  = ~mode;
        m_pt    = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check({name, "_latency"}, 128'(edges + 1), 128'(33 + nstall));
    check({name, "_done_state"}, 128'({m_busy, m_st}), 128'(5'b0_0010));
    m_valid = 1'b1;
    m_start = pulse;   // a start seen in DONE must be dropped
    @(posedge clk); #1;
    m_start = 1'b0;
    check({name, "_idle_state"}, 128'({m_busy, m_st}), 128'd0);
    check({name, "_ct_held"}, m_ct, exp);
  endtask

  task automatic run1(input bit sel, input logic mode, input logic [127:0] pt,
                      input logic [63:0] key, input logic [127:0] exp, input string name);
    int edges;
    @(posedge clk); #1;
    if (sel) begin
      b_start = 1'b1; b_mode = mode; b_pt = pt[63:0]; b_key = key[31:0];
      b_q.push_back(exp);
    end else begin
      a_start = 1'b1; a_mode = mode; a_pt = pt; a_key = key;
      a_q.push_back(exp);
    end
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    check({name, "_busy_kidx"}, 128'(sel ? {b_busy, b_kidx} : {a_busy, a_kidx}), 128'(2'b10));
    edges = 0;
    while (1) begin
      @(negedge clk);
      if ((sel ? b_fin : a_fin) || edges > 20) break;
      @(posedge clk); #1;
      edges++;
    end
    check({name, "_latency"}, 128'(edges + 1), 128'd2);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic         mode;
    logic [127:0] pt;
    logic [63:0]  key;
    logic [127:0] exp;
  } r1vec_t;

  typedef struct {
    logic         mode;
    logic [127:0] pt;
    logic [127:0] exp;
    int           nstall;
    bit           pulse;
  } mvec_t;

  localparam logic [127:0] GOLD_PT = 128'h6c617669757165207469206564616d20;
  localparam logic [127:0] GOLD_CT = 128'ha65d9851797832657860fedf5c570d18;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    r1vec_t t1[9];
    mvec_t  tm[6];
    logic [63:0] kl, kk;
    logic [127:0] rnd;

    rst = 1'b1;
    m_start = 0; m_mode = 0; m_valid = 1; m_pt = '0;
    a_start = 0; a_mode = 0; a_valid = 1; a_pt = '0; a_key = '0;
    b_start = 0; b_mode = 0; b_valid = 1; b_pt = '0; b_key = '0;

    // SPECK128/128 key schedule for key 0f0e0d0c0b0a0908_0706050403020100
    kl = 64'h0f0e0d0c0b0a0908;
    kk = 64'h0706050403020100;
    rk[0] = kk;
    for (int i = 0; i < 31; i++) begin
      kl = (kk + r8(kl)) ^ 64'(i);
      kk = l3(kk) ^ kl;
      rk[i+1] = kk;
    end

    t1[0] = '{1'b0, {64'h0, 64'h1}, 64'h0, {64'h1, 64'h9}};
    t1[1] = '{1'b1, {64'h1, 64'h9}, 64'h0, {64'h0, 64'h1}};
    t1[2] = '{1'b0, {64'h0, 64'h0}, 64'h1, {64'h1, 64'h1}};
    t1[3] = '{1'b1, {64'h1, 64'h1}, 64'h1, {64'h0, 64'h0}};
    t1[4] = '{1'b0, {64'h100, 64'h0}, 64'h0, {64'h1, 64'h1}};
    t1[5] = '{1'b0, {64'h1, 64'h0}, 64'h0, {64'h0100000000000000, 64'h0100000000000000}};
    t1[6] = '{1'b0, {64'h0, 64'hffffffffffffffff}, 64'h0, {64'hffffffffffffffff, 64'h0}};
    t1[7] = '{1'b0, {64'h100, 64'hffffffffffffffff}, 64'h0, {64'h0, 64'hffffffffffffffff}};
    t1[8] = '{1'b1, {64'h0, 64'hffffffffffffffff}, 64'h0, {64'h100, 64'hffffffffffffffff}};

    rnd = {$urandom, $urandom, $urandom, $urandom};
    tm[0] = '{1'b0, GOLD_PT, GOLD_CT, 0, 1'b0};
    tm[1] = '{1'b1, GOLD_CT, GOLD_PT, 0, 1'b0};
    tm[2] = '{1'b0, GOLD_PT, GOLD_CT, 3, 1'b0};
    tm[3] = '{1'b1, GOLD_CT, GOLD_PT, 3, 1'b0};
    tm[4] = '{1'b0, rnd, enc_model(rnd), 0, 1'b1};
    tm[5] = '{1'b1, enc_model(rnd), rnd, 3, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_main_outputs", {m_ct[126:0], m_fin}, 128'd0);
    check("reset_main_state", 128'({m_busy, m_st, m_kidx}), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run1(1'b0, t1[i].mode, t1[i].pt, t1[i].key, t1[i].exp, $sformatf("r1_vec%0d", i));

    run1(1'b1, 1'b0, 128'({32'h0, 32'h1}), 64'h0, 128'({32'h1, 32'h9}), "w32_basic");
    run1(1'b1, 1'b0, 128'({32'h1, 32'h0}), 64'h0, 128'({32'h01000000, 32'h01000000}), "w32_rot");
    run1(1'b1, 1'b1, 128'({32'h1, 32'h9}), 64'h0, 128'({32'h0, 32'h1}), "w32_dec");

    for (int i = 0; i < 6; i++)
      run_main(tm[i].mode, tm[i].pt, tm[i].exp, tm[i].nstall, tm[i].pulse,
               $sformatf("main_vec%0d", i));

    // Reset in the middle of a job abandons it.
    @(posedge clk); #1;
    m_start = 1'b1; m_mode = 1'b0; m_pt = GOLD_PT; m_valid = 1'b1;
    m_q.push_back(GOLD_CT);
    @(posedge clk); #1;
    m_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midjob_kidx_before_reset", 128'(m_kidx), 128'd10);
    rst = 1'b1;
    #1;
    check("midjob_reset_ct", m_ct, 128'd0);
    check("midjob_reset_ctrl", 128'({m_fin, m_busy, m_st, m_kidx}), 128'd0);
    void'(m_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    run_main(1'b0, GOLD_PT, GOLD_CT, 0, 1'b0, "after_reset");

    repeat (5) @(posedge clk);
    #1;
    check("scoreboards_drained", 128'(m_q.size() + a_q.size() + b_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
